// File: rtl/jelly_img_delta_decoder_pkg.sv
// jelly_img_delta_decoder_pkg: predictor-source selection shared by the delta decoder slices.
package jelly_img_delta_decoder_pkg;

    typedef enum logic [1:0] {PRED_INIT, PRED_HEAD, PRED_LAST} pred_sel_t;

    function automatic pred_sel_t pred_select(input logic pixel_first, input logic line_first);
        return pixel_first ? (line_first ? PRED_INIT : PRED_HEAD) : PRED_LAST;
    endfunction

endpackage

// File: rtl/jelly_img_delta_decoder_unit.sv
// jelly_img_delta_decoder_unit: one component's predictor, adder and clip detector holding last/head.
// Clamps instead of wrapping when JELLY_IMG_DELTA_DECODER_SATURATE_EN is defined.
module jelly_img_delta_decoder_unit
    import jelly_img_delta_decoder_pkg::*;
#(
    parameter int                     DATA_WIDTH = 8,
    parameter int                     SUM_WIDTH  = DATA_WIDTH + 2,
    parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cke,
    input  logic                   valid,
    input  logic                   de,
    input  logic                   pixel_first,
    input  logic                   line_first,
    input  logic [DATA_WIDTH-1:0]  delta,
    output logic [DATA_WIDTH-1:0]  data,
    output logic                   clip
);

    logic [DATA_WIDTH-1:0] last;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] pred;
    logic [DATA_WIDTH-1:0] result;
    logic [SUM_WIDTH-1:0]  sum;
    logic                  over;
    pred_sel_t             sel;

    always_comb begin
        sel  = pred_select(pixel_first, line_first);
        pred = sel == PRED_INIT ? INIT_VALUE : sel == PRED_HEAD ? head : last;
        sum  = {{(SUM_WIDTH-DATA_WIDTH){1'b0}}, pred} + {{(SUM_WIDTH-DATA_WIDTH){delta[DATA_WIDTH-1]}}, delta};
        // any bit above the data range means negative or above full scale
        over = |sum[SUM_WIDTH-1:DATA_WIDTH];
`ifdef JELLY_IMG_DELTA_DECODER_SATURATE_EN
        result = sum[SUM_WIDTH-1] ? '0 : sum[DATA_WIDTH] ? '1 : sum[DATA_WIDTH-1:0];
`else
        result = sum[DATA_WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last <= INIT_VALUE;
            head <= INIT_VALUE;
            data <= '0;
            clip <= 1'b0;
        end else if (cke) begin
            data <= de ? result : pred;
            clip <= de & over;
            if (valid & de) begin
                last <= result;
                if (pixel_first) head <= result;
            end
        end
    end

endmodule

// File: rtl/jelly_img_delta_decoder.sv
// jelly_img_delta_decoder: reconstructs absolute pixels from per-component horizontal deltas, 2-cycle latency.
// Optional build macro JELLY_IMG_DELTA_DECODER_SATURATE_EN clamps results instead of wrapping.
module jelly_img_delta_decoder
    import jelly_img_delta_decoder_pkg::*;
#(
    parameter int USER_WIDTH = 0,
    parameter int COMPONENTS = 1,
    parameter int DATA_WIDTH = 8,
    parameter int INIT_VALUE = 2 ** (DATA_WIDTH - 1),
    parameter int USER_BITS  = USER_WIDTH > 0 ? USER_WIDTH : 1
)(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cke,
    input  logic                             s_img_line_first,
    input  logic                             s_img_line_last,
    input  logic                             s_img_pixel_first,
    input  logic                             s_img_pixel_last,
    input  logic                             s_img_de,
    input  logic [USER_BITS-1:0]             s_img_user,
    input  logic [COMPONENTS*DATA_WIDTH-1:0] s_img_delta,
    input  logic                             s_img_valid,
    output logic                             m_img_line_first,
    output logic                             m_img_line_last,
    output logic                             m_img_pixel_first,
    output logic                             m_img_pixel_last,
    output logic                             m_img_de,
    output logic [USER_BITS-1:0]             m_img_user,
    output logic [COMPONENTS*DATA_WIDTH-1:0] m_img_delta,
    output logic [COMPONENTS*DATA_WIDTH-1:0] m_img_data,
    output logic [COMPONENTS-1:0]            m_img_clip,
    output logic                             m_img_valid
);

    localparam int                    SUM_WIDTH = DATA_WIDTH + 2;
    localparam logic [DATA_WIDTH-1:0] INIT      = DATA_WIDTH'(INIT_VALUE);

    logic                             st0_line_first;
    logic                             st0_line_last;
    logic                             st0_pixel_first;
    logic                             st0_pixel_last;
    logic                             st0_de;
    logic [USER_BITS-1:0]             st0_user;
    logic [COMPONENTS*DATA_WIDTH-1:0] st0_delta;
    logic                             st0_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            st0_line_first    <= 1'b0;
            st0_line_last     <= 1'b0;
            st0_pixel_first   <= 1'b0;
            st0_pixel_last    <= 1'b0;
            st0_de            <= 1'b0;
            st0_user          <= '0;
            st0_delta         <= '0;
            st0_valid         <= 1'b0;
            m_img_line_first  <= 1'b0;
            m_img_line_last   <= 1'b0;
            m_img_pixel_first <= 1'b0;
            m_img_pixel_last  <= 1'b0;
            m_img_de          <= 1'b0;
            m_img_user        <= '0;
            m_img_delta       <= '0;
            m_img_valid       <= 1'b0;
        end else if (cke) begin
            st0_line_first    <= s_img_line_first;
            st0_line_last     <= s_img_line_last;
            st0_pixel_first   <= s_img_pixel_first;
            st0_pixel_last    <= s_img_pixel_last;
            st0_de            <= s_img_de;
            st0_user          <= s_img_user;
            st0_delta         <= s_img_delta;
            st0_valid         <= s_img_valid;
            m_img_line_first  <= st0_line_first;
            m_img_line_last   <= st0_line_last;
            m_img_pixel_first <= st0_pixel_first;
            m_img_pixel_last  <= st0_pixel_last;
            m_img_de          <= st0_de;
            m_img_user        <= st0_user;
            m_img_delta       <= st0_delta;
            m_img_valid       <= st0_valid;
        end
    end

    for (genvar i = 0; i < COMPONENTS; i++) begin : g_unit
        jelly_img_delta_decoder_unit #(
            .DATA_WIDTH (DATA_WIDTH),
            .SUM_WIDTH  (SUM_WIDTH),
            .INIT_VALUE (INIT)
        ) u_unit (
            .clk         (clk),
            .reset       (reset),
            .cke         (cke),
            .valid       (st0_valid),
            .de          (st0_de),
            .pixel_first (st0_pixel_first),
            .line_first  (st0_line_first),
            .delta       (st0_delta[i*DATA_WIDTH +: DATA_WIDTH]),
            .data        (m_img_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .clip        (m_img_clip[i])
        );
    end

endmodule
